// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and sizes for the LED matrix frame store
package matrix_pkg;
  localparam int MAT_ROWS = 8;
  localparam int MAT_COLS = 8;
  typedef logic [MAT_COLS-1:0] row_t;
  typedef enum logic {COLOR_RED, COLOR_GREEN} color_e;
  typedef enum logic [1:0] {FS_IDLE, FS_CLEAR, FS_SWAP_WAIT} fs_state_e;
endpackage

// File: rtl/matrix_bitplane.sv
// matrix_bitplane: one 8-row plane with sync write, sync row clear and combinational read
module matrix_bitplane
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] wr_row,
  input  row_t       wr_data,
  input  logic       clr,
  input  logic [2:0] clr_row,
  input  logic [2:0] rd_row,
  output row_t       rd_data
);
  row_t mem [MAT_ROWS];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAT_ROWS; i++) mem[i] <= '0;
    end else begin
      if (we) mem[wr_row] <= wr_data;
      if (clr) mem[clr_row] <= '0;
    end
  end
  assign rd_data = mem[rd_row];
endmodule

// File: rtl/matrix_frame_store.sv
// matrix_frame_store: double-buffered red/green frame store with tear-free swap on frame boundary
module matrix_frame_store
  import matrix_pkg::*;
#(
  parameter int ROWS = MAT_ROWS,
  parameter int COLS = MAT_COLS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [2:0]      wr_row,
  input  logic            wr_color,
  input  logic [COLS-1:0] wr_data,
  input  logic            clr_req,
  input  logic            swap_req,
  input  logic            frame_sync,
  output logic            swap_pending,
  output logic            swap_done,
  input  logic [2:0]      rd_row,
  output logic [COLS-1:0] rd_red,
  output logic [COLS-1:0] rd_green
);
  fs_state_e  state, state_nxt;
  logic [2:0] clr_cnt;
  logic       front_sel;
  logic       accept;
  logic       swap_now;
  row_t       plane_rd [2][2];
  assign wr_ready     = state == FS_IDLE;
  assign swap_pending = state == FS_SWAP_WAIT;
  assign accept       = wr_valid & wr_ready;
  assign swap_now     = swap_pending & frame_sync;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < 2; c++) begin : g_plane
      matrix_bitplane u_plane (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept && 1'(b) != front_sel && wr_color == 1'(c)),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .clr     (state == FS_CLEAR && 1'(b) != front_sel),
        .clr_row (clr_cnt),
        .rd_row  (rd_row),
        .rd_data (plane_rd[b][c])
      );
    end
  end
  always_comb begin
    state_nxt = state == FS_IDLE  ? (clr_req ? FS_CLEAR : swap_req ? FS_SWAP_WAIT : FS_IDLE) :
                state == FS_CLEAR ? (clr_cnt == 3'd7 ? FS_IDLE : FS_CLEAR) :
                (state == FS_SWAP_WAIT && !frame_sync) ? FS_SWAP_WAIT : FS_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FS_IDLE;
      clr_cnt   <= '0;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
      rd_red    <= '0;
      rd_green  <= '0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= state == FS_CLEAR ? clr_cnt + 3'd1 : 3'd0;
      front_sel <= front_sel ^ swap_now;
      swap_done <= swap_now;
      rd_red    <= plane_rd[front_sel][COLOR_RED];
      rd_green  <= plane_rd[front_sel][COLOR_GREEN];
    end
  end
endmodule

// File: tb/tb_matrix_frame_store.sv
// tb_matrix_frame_store: random and directed checks against a behavioural frame-store model
module tb_matrix_frame_store;
  logic       clk = 0;
  logic       rst_n, wr_valid, wr_ready, wr_color, clr_req, swap_req, frame_sync;
  logic       swap_pending, swap_done;
  logic [2:0] wr_row, rd_row;
  logic [7:0] wr_data, rd_red, rd_green;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  matrix_frame_store dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
    .wr_color(wr_color), .wr_data(wr_data), .clr_req(clr_req), .swap_req(swap_req),
    .frame_sync(frame_sync), .swap_pending(swap_pending), .swap_done(swap_done),
    .rd_row(rd_row), .rd_red(rd_red), .rd_green(rd_green)
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [7:0] mem [2][2][8];
  int         front, mode, clr_rows;
  logic [7:0] e_red, e_green;
  logic       e_done, started = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) for (int c = 0; c < 2; c++) for (int r = 0; r < 8; r++) mem[b][c][r] = 8'h00;
      front = 0; mode = 0; clr_rows = 0; e_red = 0; e_green = 0; e_done = 0; started = 1;
    end else if (started) begin
      e_red   = mem[front][0][rd_row];
      e_green = mem[front][1][rd_row];
      e_done  = 0;
      if (mode == 0) begin
        if (wr_valid) mem[1-front][wr_color][wr_row] = wr_data;
        if (clr_req) begin mode = 1; clr_rows = 0; end
        else if (swap_req) mode = 2;
      end else if (mode == 1) begin
        mem[1-front][0][clr_rows] = 8'h00;
        mem[1-front][1][clr_rows] = 8'h00;
        clr_rows++;
        if (clr_rows == 8) mode = 0;
      end else if (frame_sync) begin
        front = 1 - front; e_done = 1; mode = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("wr_ready", {7'd0, wr_ready}, {7'd0, mode == 0});
      chk("swap_pending", {7'd0, swap_pending}, {7'd0, mode == 2});
      chk("swap_done", {7'd0, swap_done}, {7'd0, e_done});
      chk("rd_red", rd_red, e_red);
      chk("rd_green", rd_green, e_green);
    end
  end
  task automatic idle_in();
    wr_valid = 0; clr_req = 0; swap_req = 0; frame_sync = 0;
  endtask
  task automatic write(input logic [2:0] r, input logic c, input logic [7:0] d);
    wr_valid = 1; wr_row = r; wr_color = c; wr_data = d;
    @(negedge clk);
    wr_valid = 0;
  endtask
  task automatic do_swap();
    swap_req = 1; @(negedge clk); swap_req = 0;
    repeat (3) @(negedge clk);
    frame_sync = 1; @(negedge clk); frame_sync = 0;
    @(negedge clk);
  endtask
  task automatic read_chk(input string nm, input logic [2:0] r, input logic [7:0] er, input logic [7:0] eg);
    rd_row = r; @(negedge clk);
    chk({nm, "_red"}, rd_red, er);
    chk({nm, "_green"}, rd_green, eg);
  endtask
  task automatic do_reset();
    rst_n = 0; idle_in(); @(negedge clk); rst_n = 1;
    chk("rst_wr_ready", {7'd0, wr_ready}, 8'd1);
    chk("rst_pending", {7'd0, swap_pending}, 8'd0);
    chk("rst_done", {7'd0, swap_done}, 8'd0);
    chk("rst_red", rd_red, 8'h00);
    chk("rst_green", rd_green, 8'h00);
  endtask
  initial begin
    int n;
    idle_in(); rst_n = 0; wr_row = 0; wr_color = 0; wr_data = 0; rd_row = 0;
    @(negedge clk); @(negedge clk);
    do_reset();
    for (int r = 0; r < 8; r++) read_chk("post_reset", 3'(r), 8'h00, 8'h00);
    write(3, 0, 8'hF0); write(3, 1, 8'h0F);
    swap_req = 1; @(negedge clk); swap_req = 0; rd_row = 3;
    repeat (20) @(negedge clk);
    chk("hold_red", rd_red, 8'h00);
    chk("hold_pending", {7'd0, swap_pending}, 8'd1);
    chk("hold_ready", {7'd0, wr_ready}, 8'd0);
    frame_sync = 1; @(negedge clk); frame_sync = 0;
    chk("swap_pulse", {7'd0, swap_done}, 8'd1);
    @(negedge clk);
    chk("swap_pulse_end", {7'd0, swap_done}, 8'd0);
    chk("swapped_red", rd_red, 8'hF0);
    chk("swapped_green", rd_green, 8'h0F);
    chk("swapped_pending", {7'd0, swap_pending}, 8'd0);
    for (int r = 0; r < 8; r++) begin write(3'(r), 0, 8'hFF); write(3'(r), 1, 8'hFF); end
    clr_req = 1; @(negedge clk); clr_req = 0;
    n = 0;
    while (!wr_ready && n < 20) begin n++; @(negedge clk); end
    chk("clear_cycles", 8'(n), 8'd8);
    do_swap();
    for (int r = 0; r < 8; r++) read_chk("cleared", 3'(r), 8'h00, 8'h00);
    do_swap();
    read_chk("old_front", 3, 8'hF0, 8'h0F);
    wr_valid = 1; wr_row = 1; wr_color = 0; wr_data = 8'hAA; clr_req = 1; swap_req = 1;
    @(negedge clk); idle_in();
    chk("combo_ready", {7'd0, wr_ready}, 8'd0);
    chk("combo_pending", {7'd0, swap_pending}, 8'd0);
    repeat (8) @(negedge clk);
    do_swap();
    read_chk("combo_row1", 1, 8'h00, 8'h00);
    write(2, 1, 8'h5A);
    clr_req = 1; @(negedge clk); clr_req = 0;
    repeat (3) @(negedge clk);
    do_reset();
    for (int r = 0; r < 8; r++) read_chk("rst_clear_mem", 3'(r), 8'h00, 8'h00);
    write(4, 0, 8'h3C);
    swap_req = 1; @(negedge clk); swap_req = 0;
    repeat (2) @(negedge clk);
    do_reset();
    do_swap();
    read_chk("rst_wait_mem", 4, 8'h00, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      wr_valid   = $urandom_range(0, 1) == 1;
      wr_row     = 3'($urandom);
      wr_color   = 1'($urandom);
      wr_data    = 8'($urandom);
      clr_req    = $urandom_range(0, 39) == 0;
      swap_req   = $urandom_range(0, 9) == 0;
      frame_sync = $urandom_range(0, 7) == 0;
      rd_row     = 3'($urandom);
      @(negedge clk);
    end
    rst_n = 1; idle_in();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_frame_store.md
# matrix_frame_store

Double-buffered frame store for the 8x8 red/green LED matrix, sitting directly upstream of the matrix row scanner. Producers write rows into a back buffer via valid/ready; the scanner reads the front buffer by row index. A requested swap is applied only on the scanner's frame-boundary pulse, so a displayed frame never tears. A back-buffer clear command is also provided.

## Interface
- `ROWS`, 8, matrix rows; fixed at 8 (row index 3 bits).
- `COLS`, 8, matrix columns; width of one row word.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_valid`  in  1  row write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`.
- `wr_row`  in  3  target row in the back buffer.
- `wr_color`  in  1  plane select: 0 = red, 1 = green.
- `wr_data`  in  8  row bits; bit n = column n; 1 = LED on.
- `clr_req`  in  1  single-cycle request to zero both planes of the back buffer.
- `swap_req`  in  1  single-cycle request to exchange front and back at the next frame boundary.
- `frame_sync`  in  1  single-cycle pulse from the scanner when its row counter wraps 7→0.
- `swap_pending`  out  1  high from swap acceptance until the swap is applied.
- `swap_done`  out  1  one-cycle pulse in the cycle the swap is applied.
- `rd_row`  in  3  scanner row index.
- `rd_red`  out  8  front-buffer red row `rd_row`, registered.
- `rd_green`  out  8  front-buffer green row `rd_row`, registered.

## Operation
- Storage: two banks (A, B), each with a red and a green plane of 8x8 bits. `front_sel` picks the front bank; the other bank is the back.
- FSM states:
  - IDLE: `wr_ready`=1.
    - `clr_req` → CLEAR with `clr_cnt`=0.
    - else `swap_req` → SWAP_WAIT.
    - other requests in IDLE are not stored.
  - CLEAR: `wr_ready`=0. Each cycle zero back row `clr_cnt` in both planes and increment. When `clr_cnt`=7 → IDLE. Exactly 8 cycles.
  - SWAP_WAIT: `wr_ready`=0, `swap_pending`=1. On `frame_sync`: toggle `front_sel`, pulse `swap_done`, → IDLE.
- `clr_req`/`swap_req` outside IDLE are dropped. No queueing.
- Same-cycle `clr_req` and `swap_req` in IDLE: clear wins; swap is dropped.
- A write accepted in the same IDLE cycle as `clr_req` is committed first. The clear then overwrites it.
- `frame_sync` outside SWAP_WAIT has no effect.
- `rd_*` always come from the front bank; the write and clear paths never touch the front bank.
- Writes are whole-row: `wr_data` replaces the addressed back row in the selected plane.

## Timing
- Write latency: a row accepted at edge N is stored after edge N. It becomes visible on `rd_*` only after a swap.
- Read latency: 1 cycle. `rd_*` at edge N+1 reflect `rd_row` and `front_sel` sampled at edge N.
- Swap:
  - `front_sel` changes at the edge sampling `frame_sync` in SWAP_WAIT.
  - `swap_done` is high for the following cycle.
  - `rd_*` show the new bank one edge after that.
- `swap_req` at edge N gives `swap_pending`=1 from after N. The earliest swap is at the next `frame_sync`, sampled at N+1 or later.
- Reset (`rst_n`=0 at an edge):
  - all 256 storage bits cleared; `front_sel`=0; FSM=IDLE; `clr_cnt`=0.
  - outputs: `wr_ready`=1, `swap_pending`=0, `swap_done`=0, `rd_red`=0, `rd_green`=0.
  - reset mid-CLEAR or mid-SWAP_WAIT abandons the operation.

## Structure
- `matrix_pkg` holds:
  - `MAT_ROWS`=8, `MAT_COLS`=8.
  - `typedef logic [7:0] row_t`.
  - `typedef enum logic {COLOR_RED, COLOR_GREEN} color_e`.
  - `typedef enum logic [1:0] {FS_IDLE, FS_CLEAR, FS_SWAP_WAIT} fs_state_e`.
- Sub-module `matrix_bitplane` is one 8x`row_t` plane with:
  - a synchronous write port (row, data, we);
  - a synchronous clear-row port;
  - a combinational read by row.
- Top level instantiates `matrix_bitplane` 4 times (bank A/B × red/green) and owns the FSM, `front_sel` and the output registers.

## Test plan
- Reset, then `rd_row`=0..7 → `rd_red`=`rd_green`=8'h00 on every row; `wr_ready`=1; `swap_pending`=0.
- Write red row 3 = 8'hF0 and green row 3 = 8'h0F, then `swap_req`; no `frame_sync` for 20 cycles → `rd_*` row 3 stay 8'h00, `swap_pending`=1, `wr_ready`=0.
- Continue the previous scenario: pulse `frame_sync` → `swap_done` for 1 cycle; one cycle later row 3 reads red 8'hF0 / green 8'h0F; `swap_pending`=0.
- Fill the back rows with 8'hFF, then `clr_req` → `wr_ready`=0 for exactly 8 cycles. Swap → all rows read 8'h00. The previous front content is now in the back bank and untouched.
- Same-cycle `clr_req` + `swap_req` + accepted write (row 1, 8'hAA) in IDLE → CLEAR runs, no `swap_pending`; after a later swap row 1 reads 8'h00.
- Assert `rst_n`=0 mid-CLEAR (cycle 4) and, separately, in SWAP_WAIT → next cycle all outputs at reset values; `front_sel`=0; memory all zero.
